mc_control: RTL and testbench

Multicycle control FSM for the 16-bit TSC-style CPU. It decodes the latched instruction and sequences the shared ALU, register file, PC and memory port over the IF/ID/EX/MEM/WB steps. It drives the ALU funcCode and consumes the ALU branch flag (bResult). It also counts retired instructions and stops the core on HLT.

---
 rtl/mc_control_pkg.sv | 68 ++++++
 rtl/mc_control_decode.sv | 49 ++++
 rtl/mc_control.sv | 172 +++++++++++++++++
 tb/tb_mc_control.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_pkg.sv
// rtl/mc_control_pkg.sv - shared encodings for the multicycle control FSM
package mc_control_pkg;

  localparam int PKG_WORD_SIZE = 16;

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [3:0] OPCODE_BNE   = 4'd0;
  localparam logic [3:0] OPCODE_BEQ   = 4'd1;
  localparam logic [3:0] OPCODE_BGZ   = 4'd2;
  localparam logic [3:0] OPCODE_BLZ   = 4'd3;
  localparam logic [3:0] OPCODE_ADI   = 4'd4;
  localparam logic [3:0] OPCODE_ORI   = 4'd5;
  localparam logic [3:0] OPCODE_LHI   = 4'd6;
  localparam logic [3:0] OPCODE_LWD   = 4'd7;
  localparam logic [3:0] OPCODE_SWD   = 4'd8;
  localparam logic [3:0] OPCODE_JMP   = 4'd9;
  localparam logic [3:0] OPCODE_JAL   = 4'd10;
  localparam logic [3:0] OPCODE_RTYPE = 4'd15;

  localparam logic [5:0] INST_FUNC_JPR = 6'd25;
  localparam logic [5:0] INST_FUNC_JRL = 6'd26;
  localparam logic [5:0] INST_FUNC_WWD = 6'd28;
  localparam logic [5:0] INST_FUNC_HLT = 6'd29;

  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_SUB = 4'd1;
  localparam logic [3:0] FUNC_AND = 4'd2;
  localparam logic [3:0] FUNC_ORR = 4'd3;
  localparam logic [3:0] FUNC_NOT = 4'd4;
  localparam logic [3:0] FUNC_TCP = 4'd5;
  localparam logic [3:0] FUNC_SHL = 4'd6;
  localparam logic [3:0] FUNC_SHR = 4'd7;
  localparam logic [3:0] FUNC_LHI = 4'd8;
  localparam logic [3:0] FUNC_BNE = 4'd9;
  localparam logic [3:0] FUNC_BEQ = 4'd10;
  localparam logic [3:0] FUNC_BGZ = 4'd11;
  localparam logic [3:0] FUNC_BLZ = 4'd12;

  localparam logic [1:0] PC_SRC_SEQ  = 2'd0;
  localparam logic [1:0] PC_SRC_BR   = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP = 2'd2;
  localparam logic [1:0] PC_SRC_REG  = 2'd3;

  localparam logic [1:0] SRC_B_RT   = 2'd0;
  localparam logic [1:0] SRC_B_ONE  = 2'd1;
  localparam logic [1:0] SRC_B_SEXT = 2'd2;
  localparam logic [1:0] SRC_B_ZEXT = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [1:0] REG_DST_RT   = 2'd0;
  localparam logic [1:0] REG_DST_RD   = 2'd1;
  localparam logic [1:0] REG_DST_LINK = 2'd2;

  typedef enum logic [3:0] {
    C_NOP, C_RALU, C_ADI, C_ORI, C_LHI, C_LWD, C_SWD, C_BR,
    C_JMP, C_JAL, C_JPR, C_JRL, C_WWD, C_HLT
  } inst_class_t;

endpackage

// File: rtl/mc_control_decode.sv
// rtl/mc_control_decode.sv - combinational instruction classifier (mc_decode)
module mc_decode
  import mc_control_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [5:0]  func,
  output inst_class_t cls,
  output logic [3:0]  alu_func,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  reg_dst
);

  always_comb begin
    cls       = C_NOP;
    alu_func  = FUNC_ADD;
    alu_src_b = SRC_B_RT;
    reg_dst   = REG_DST_RT;
    case (opcode)
      OPCODE_RTYPE: begin
        reg_dst = REG_DST_RD;
        if (func < 6'd8) begin
          cls      = C_RALU;
          alu_func = {1'b0, func[2:0]};
        end else begin
          case (func)
            INST_FUNC_JPR: cls = C_JPR;
            INST_FUNC_JRL: cls = C_JRL;
            INST_FUNC_WWD: cls = C_WWD;
            INST_FUNC_HLT: cls = C_HLT;
            default:       cls = C_NOP;
          endcase
        end
      end
      OPCODE_ADI: begin cls = C_ADI; alu_src_b = SRC_B_SEXT; end
      OPCODE_ORI: begin cls = C_ORI; alu_func = FUNC_ORR; alu_src_b = SRC_B_ZEXT; end
      OPCODE_LHI: begin cls = C_LHI; alu_func = FUNC_LHI; alu_src_b = SRC_B_ZEXT; end
      OPCODE_LWD: begin cls = C_LWD; alu_src_b = SRC_B_SEXT; end
      OPCODE_SWD: begin cls = C_SWD; alu_src_b = SRC_B_SEXT; end
      OPCODE_BNE: begin cls = C_BR; alu_func = FUNC_BNE; end
      OPCODE_BEQ: begin cls = C_BR; alu_func = FUNC_BEQ; end
      OPCODE_BGZ: begin cls = C_BR; alu_func = FUNC_BGZ; end
      OPCODE_BLZ: begin cls = C_BR; alu_func = FUNC_BLZ; end
      OPCODE_JMP: cls = C_JMP;
      OPCODE_JAL: cls = C_JAL;
      default:    cls = C_NOP;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle IF/ID/EX/MEM/WB control FSM with retire counter
module mc_control
  import mc_control_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 alu_bcond,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic [3:0]           alu_func,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           wb_src,
  output logic                 output_port_en,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] num_inst
);

  if (WORD_SIZE != PKG_WORD_SIZE) begin : g_word_size_check
    $error("mc_control: WORD_SIZE must match the datapath word size");
  end

  logic [2:0]  state, next_state;
  logic        retire;
  logic [3:0]  ex_func_q;
  inst_class_t cls;
  logic [3:0]  dec_alu_func;
  logic [1:0]  dec_src_b;
  logic [1:0]  dec_reg_dst;

  mc_decode u_decode (
    .opcode    (opcode),
    .func      (func),
    .cls       (cls),
    .alu_func  (dec_alu_func),
    .alu_src_b (dec_src_b),
    .reg_dst   (dec_reg_dst)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IF;
      num_inst  <= '0;
      ex_func_q <= FUNC_ADD;
    end else begin
      state <= next_state;
      if (retire) num_inst <= num_inst + CNT_WIDTH'(1);
      if (state == S_EX) ex_func_q <= dec_alu_func;
    end
  end

  always_comb begin
    next_state     = state;
    retire         = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    iord           = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = PC_SRC_SEQ;
    alu_func       = FUNC_ADD;
    alu_src_a      = 1'b0;
    alu_src_b      = SRC_B_RT;
    reg_write      = 1'b0;
    reg_dst        = REG_DST_RT;
    wb_src         = WB_ALU;
    output_port_en = 1'b0;
    halted         = 1'b0;
    case (state)
      S_IF: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_ID;
        end
      end
      S_ID: begin
        // ALU precomputes PC + sign-ext imm so the branch target is ready for EX
        alu_src_b = SRC_B_SEXT;
        next_state = S_IF;
        retire     = 1'b1;
        case (cls)
          C_HLT: begin next_state = S_HALT; retire = 1'b0; end
          C_JMP: begin pc_write = 1'b1; pc_src = PC_SRC_JUMP; end
          C_JPR: begin pc_write = 1'b1; pc_src = PC_SRC_REG; end
          C_JAL, C_JRL: begin
            pc_write  = 1'b1;
            pc_src    = (cls == C_JAL) ? PC_SRC_JUMP : PC_SRC_REG;
            reg_write = 1'b1;
            reg_dst   = REG_DST_LINK;
            wb_src    = WB_PC;
          end
          C_WWD: output_port_en = 1'b1;
          C_NOP: ;
          default: begin next_state = S_EX; retire = 1'b0; end
        endcase
      end
      S_EX: begin
        alu_func  = dec_alu_func;
        alu_src_a = 1'b1;
        alu_src_b = dec_src_b;
        if (cls == C_BR) begin
          if (alu_bcond) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_BR;
          end
          retire     = 1'b1;
          next_state = S_IF;
        end else if (cls == C_LWD || cls == C_SWD) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        alu_func = ex_func_q;
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_we   = (cls == C_SWD);
        if (mem_ack) begin
          if (cls == C_SWD) begin
            retire     = 1'b1;
            next_state = S_IF;
          end else begin
            next_state = S_WB;
          end
        end
      end
      S_WB: begin
        alu_func   = ex_func_q;
        reg_write  = 1'b1;
        reg_dst    = dec_reg_dst;
        wb_src     = (cls == C_LWD) ? WB_MDR : WB_ALU;
        retire     = 1'b1;
        next_state = S_IF;
      end
      S_HALT: halted = 1'b1;
      default: next_state = S_IF;
    endcase
    // Reset silences the datapath immediately, including an in-flight memory request
    if (reset) begin
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      iord           = 1'b0;
      ir_write       = 1'b0;
      pc_write       = 1'b0;
      pc_src         = PC_SRC_SEQ;
      alu_func       = FUNC_ADD;
      alu_src_a      = 1'b0;
      alu_src_b      = SRC_B_RT;
      reg_write      = 1'b0;
      reg_dst        = REG_DST_RT;
      wb_src         = WB_ALU;
      output_port_en = 1'b0;
      halted         = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - scoreboard bench for the multicycle control FSM
module tb_mc_control;
  import mc_control_pkg::*;

  logic        clk = 1'b0;
  logic        reset, alu_bcond, mem_ack;
  logic [3:0]  opcode;
  logic [5:0]  func;
  logic        mem_req, mem_we, iord, ir_write, pc_write, alu_src_a;
  logic        reg_write, output_port_en, halted;
  logic [1:0]  pc_src, alu_src_b, reg_dst, wb_src;
  logic [3:0]  alu_func;
  logic [15:0] num_inst;

  int errors = 0;
  int checks = 0;
  int exp_num = 0;

  typedef struct {
    int cycles; int nreg; int reg_dst; int wb_src; int wb_func; int rw_pcw;
    int extra_pcw; int extra_src; int ex_func; int nport; int mreq; int iord1;
    int nwe; int num;
  } rec_t;

  rec_t exp_q[$];

  mc_control #(.WORD_SIZE(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func),
    .alu_bcond(alu_bcond), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_func(alu_func), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .reg_dst(reg_dst),
    .wb_src(wb_src), .output_port_en(output_port_en), .halted(halted),
    .num_inst(num_inst)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic rec_t mk(input int cycles, input int mreq);
    rec_t r;
    r = '{default: 0};
    r.cycles = cycles;
    r.mreq   = mreq;
    return r;
  endfunction

  // Drives one instruction from IF to retirement (or halt); the scoreboard entry is popped afterwards
  task automatic run_inst(input string tag, input logic [3:0] op, input logic [5:0] fn,
                          input logic bc, input int if_wait, input int mem_wait, input rec_t e);
    rec_t o, x;
    int wcnt;
    bit done;
    logic [15:0] start;
    exp_q.push_back(e);
    opcode = op; func = fn; alu_bcond = bc;
    o = '{default: 0};
    wcnt = 0; done = 0; start = num_inst;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (mem_req) begin
        if (wcnt == (iord ? mem_wait : if_wait)) begin mem_ack = 1'b1; wcnt = 0; end
        else wcnt++;
      end
      #1;
      o.cycles++;
      if (mem_req) begin
        o.mreq++;
        if (iord) o.iord1++;
        if (mem_we) o.nwe++;
      end
      if (reg_write) begin
        o.nreg++; o.reg_dst = reg_dst; o.wb_src = wb_src;
        o.wb_func = alu_func; o.rw_pcw = pc_write;
      end
      if (pc_write && !ir_write) begin o.extra_pcw++; o.extra_src = pc_src; end
      if (alu_src_a) o.ex_func = alu_func;
      if (output_port_en) o.nport++;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (num_inst != start || halted) done = 1;
    end
    o.num = num_inst;
    check({tag, ".done"}, done, 1);
    x = exp_q.pop_front();
    check({tag, ".cycles"},    o.cycles,    x.cycles);
    check({tag, ".num_inst"},  o.num,       x.num);
    check({tag, ".mem_req"},   o.mreq,      x.mreq);
    check({tag, ".iord"},      o.iord1,     x.iord1);
    check({tag, ".mem_we"},    o.nwe,       x.nwe);
    check({tag, ".reg_write"}, o.nreg,      x.nreg);
    check({tag, ".reg_dst"},   o.reg_dst,   x.reg_dst);
    check({tag, ".wb_src"},    o.wb_src,    x.wb_src);
    check({tag, ".wb_func"},   o.wb_func,   x.wb_func);
    check({tag, ".rw_pcw"},    o.rw_pcw,    x.rw_pcw);
    check({tag, ".pc_write"},  o.extra_pcw, x.extra_pcw);
    check({tag, ".pc_src"},    o.extra_src, x.extra_src);
    check({tag, ".ex_func"},   o.ex_func,   x.ex_func);
    check({tag, ".port_en"},   o.nport,     x.nport);
  endtask

  initial begin
    rec_t e;
    int bad_req, bad_num;
    reset = 1'b1; mem_ack = 1'b0; alu_bcond = 1'b0; opcode = '0; func = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.mem_req",   mem_req,   0);
    check("rst.num_inst",  num_inst,  0);
    check("rst.halted",    halted,    0);
    check("rst.alu_func",  alu_func,  0);
    check("rst.pc_src",    pc_src,    0);
    check("rst.reg_write", reg_write, 0);
    check("rst.ir_write",  ir_write,  0);
    @(negedge clk); reset = 1'b0; #1;
    check("rst.fetch", {mem_req, iord}, 2'b10);
    @(posedge clk); #1;

    // ADD: IF,ID,EX,WB
    e = mk(4, 1); e.nreg = 1; e.reg_dst = 1; e.num = ++exp_num;
    run_inst("add", OPCODE_RTYPE, 6'd0, 1'b0, 0, 0, e);
    // SUB: alu_func must survive from EX into WB
    e = mk(4, 1); e.nreg = 1; e.reg_dst = 1; e.ex_func = 1; e.wb_func = 1; e.num = ++exp_num;
    run_inst("sub", OPCODE_RTYPE, 6'd1, 1'b0, 0, 0, e);
    // LWD with 3 wait cycles on both memory accesses
    e = mk(11, 8); e.iord1 = 4; e.nreg = 1; e.reg_dst = 0; e.wb_src = 1; e.num = ++exp_num;
    run_inst("lwd", OPCODE_LWD, 6'd0, 1'b0, 3, 3, e);
    e = mk(3, 1); e.extra_pcw = 1; e.extra_src = 1; e.ex_func = 10; e.num = ++exp_num;
    run_inst("beq_t", OPCODE_BEQ, 6'd0, 1'b1, 0, 0, e);
    e = mk(3, 1); e.ex_func = 10; e.num = ++exp_num;
    run_inst("beq_nt", OPCODE_BEQ, 6'd0, 1'b0, 0, 0, e);
    e = mk(2, 1); e.num = exp_num;
    run_inst("hlt", OPCODE_RTYPE, 6'd29, 1'b0, 0, 0, e);

    bad_req = 0; bad_num = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) bad_req++;
      if (num_inst != 16'd5 || !halted) bad_num++;
    end
    check("halt.mem_req", bad_req, 0);
    check("halt.frozen", bad_num, 0);
    check("halt.num_inst", num_inst, 5);

    reset = 1'b1;
    @(posedge clk); #1;
    check("halt_rst.num_inst", num_inst, 0);
    check("halt_rst.halted", halted, 0);
    @(negedge clk); reset = 1'b0; #1;
    check("halt_rst.fetch", {mem_req, iord}, 2'b10);
    @(posedge clk); #1;
    exp_num = 0;

    e = mk(2, 1); e.nreg = 1; e.reg_dst = 2; e.wb_src = 2; e.rw_pcw = 1;
    e.extra_pcw = 1; e.extra_src = 2; e.num = ++exp_num;
    run_inst("jal", OPCODE_JAL, 6'd0, 1'b0, 0, 0, e);
    e = mk(2, 1); e.nport = 1; e.num = ++exp_num;
    run_inst("wwd", OPCODE_RTYPE, 6'd28, 1'b0, 0, 0, e);
    e = mk(4, 2); e.iord1 = 1; e.nwe = 1; e.num = ++exp_num;
    run_inst("swd", OPCODE_SWD, 6'd0, 1'b0, 0, 0, e);
    e = mk(4, 1); e.nreg = 1; e.ex_func = 3; e.wb_func = 3; e.num = ++exp_num;
    run_inst("ori", OPCODE_ORI, 6'd0, 1'b0, 0, 0, e);
    e = mk(2, 1); e.num = ++exp_num;
    run_inst("undef", OPCODE_RTYPE, 6'd40, 1'b0, 0, 0, e);

    // Reset while SWD waits in MEM
    opcode = OPCODE_SWD; func = '0;
    @(negedge clk); mem_ack = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("mrst.in_mem", {mem_req, iord, mem_we}, 3'b111);
    reset = 1'b1; #1;
    check("mrst.abort_now", mem_req, 0);
    @(posedge clk); #1;
    check("mrst.abort_next", mem_req, 0);
    check("mrst.num_inst", num_inst, 0);
    reset = 1'b0; #1;
    check("mrst.refetch", {mem_req, iord, mem_we, reg_write}, 4'b1000);
    exp_num = 0;

    e = mk(4, 1); e.nreg = 1; e.reg_dst = 1; e.num = ++exp_num;
    run_inst("add2", OPCODE_RTYPE, 6'd0, 1'b0, 0, 0, e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
